// File: rtl/regime_ctrl.sv
// regime_ctrl: sequences the s/y datapath registers through
// countdown, per-channel count and all-channel update regimes.
module regime_ctrl #(
    parameter int N_CH     = 4,
    parameter int CH_W     = 2,
    parameter int VAL_W    = 4,
    parameter int DWELL    = 3,
    parameter int CD_START = 6,
    parameter int CD_STEP  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       i_mode,
    input  logic             i_start,
    input  logic [CH_W-1:0]  i_ch_sel,
    input  logic             i_carry,
    output logic [1:0]       o_regime,
    output logic             o_active,
    output logic [CH_W-1:0]  o_ch,
    output logic             o_s_en,
    output logic [1:0]       o_s_op,
    output logic [VAL_W-1:0] o_s_val,
    output logic             o_y_en,
    output logic [1:0]       o_y_sel,
    output logic             o_done
);

    localparam logic [3:0] S_OFF     = 4'd0;
    localparam logic [3:0] S_ARM     = 4'd1;
    localparam logic [3:0] S_CD_LOAD = 4'd2;
    localparam logic [3:0] S_CD_HOLD = 4'd3;
    localparam logic [3:0] S_CD_STEP = 4'd4;
    localparam logic [3:0] S_CD_END  = 4'd5;
    localparam logic [3:0] S_CNT     = 4'd6;
    localparam logic [3:0] S_UPD_X   = 4'd7;
    localparam logic [3:0] S_UPD_NXT = 4'd8;
    localparam logic [3:0] S_UPD_CLR = 4'd9;

    localparam int DW_W = $clog2(DWELL + 1);

    localparam logic [VAL_W-1:0] W_START = VAL_W'(CD_START);
    localparam logic [VAL_W-1:0] W_STEP  = VAL_W'(CD_STEP);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N_CH - 1);
    localparam logic [DW_W-1:0]  DW_RLD  = DW_W'(DWELL - 1);

    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_ADD  = 2'd2;
    localparam logic [1:0] OP_SUB  = 2'd3;

    logic [3:0]       r_state;
    logic [VAL_W-1:0] r_cd_val;
    logic [DW_W-1:0]  r_dwell;
    logic [CH_W-1:0]  r_ch;

    logic [CH_W-1:0]  w_ch_clamp;
    logic [VAL_W-1:0] w_sub;

    // Out-of-range channel requests pin to the last channel; the
    // final step shrinks so the countdown lands on zero exactly.
    always_comb begin
        w_ch_clamp = (i_ch_sel > LAST_CH) ? LAST_CH : i_ch_sel;
        w_sub      = (r_cd_val < W_STEP) ? r_cd_val : W_STEP;
    end

    // Regime state, countdown value, dwell timer and channel pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_OFF;
            r_cd_val <= '0;
            r_dwell  <= '0;
            r_ch     <= '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    case (i_mode)
                        2'd1: r_state <= S_ARM;
                        2'd2: begin
                            r_state <= S_CNT;
                            r_ch    <= w_ch_clamp;
                        end
                        2'd3: begin
                            r_state <= S_UPD_X;
                            r_ch    <= '0;
                        end
                        default: r_state <= S_OFF;
                    endcase
                end
                S_ARM: begin
                    if (i_start)
                        r_state <= S_CD_LOAD;
                    else if (i_mode == 2'd0)
                        r_state <= S_OFF;
                end
                S_CD_LOAD: begin
                    r_cd_val <= W_START;
                    r_dwell  <= DW_RLD;
                    r_state  <= S_CD_HOLD;
                end
                S_CD_HOLD: begin
                    if (r_dwell == '0)
                        r_state <= (r_cd_val == '0) ? S_CD_END
                                                    : S_CD_STEP;
                    else
                        r_dwell <= r_dwell - DW_W'(1);
                end
                S_CD_STEP: begin
                    r_cd_val <= r_cd_val - w_sub;
                    r_dwell  <= DW_RLD;
                    r_state  <= S_CD_HOLD;
                end
                S_CD_END: r_state <= S_OFF;
                S_CNT: begin
                    if (!i_start)
                        r_state <= S_OFF;
                end
                S_UPD_X:   r_state <= S_UPD_NXT;
                S_UPD_NXT: r_state <= S_UPD_CLR;
                S_UPD_CLR: begin
                    if (r_ch == LAST_CH) begin
                        r_ch    <= '0;
                        r_state <= S_OFF;
                    end else begin
                        r_ch    <= r_ch + CH_W'(1);
                        r_state <= S_UPD_X;
                    end
                end
                default: r_state <= S_OFF;
            endcase
        end
    end

    // Strobe decode: only the count regime looks at live inputs.
    always_comb begin
        o_regime = 2'd0;
        o_active = 1'b0;
        o_ch     = '0;
        o_s_en   = 1'b0;
        o_s_op   = 2'd0;
        o_s_val  = '0;
        o_y_en   = 1'b0;
        o_y_sel  = 2'd0;
        o_done   = 1'b0;
        case (r_state)
            S_ARM: o_regime = 2'd1;
            S_CD_LOAD: begin
                o_regime = 2'd1;
                o_active = 1'b1;
                o_s_en   = 1'b1;
                o_s_op   = OP_LOAD;
                o_s_val  = W_START;
            end
            S_CD_HOLD: begin
                o_regime = 2'd1;
                o_active = 1'b1;
            end
            S_CD_STEP: begin
                o_regime = 2'd1;
                o_active = 1'b1;
                o_s_en   = 1'b1;
                o_s_op   = OP_SUB;
                o_s_val  = w_sub;
            end
            S_CD_END: begin
                o_regime = 2'd1;
                o_active = 1'b1;
                o_s_en   = 1'b1;
                o_s_op   = OP_LOAD;
                o_s_val  = W_START;
                o_done   = 1'b1;
            end
            S_CNT: begin
                o_regime = 2'd2;
                o_ch     = r_ch;
                if (i_start) begin
                    o_s_en  = 1'b1;
                    o_s_op  = OP_ADD;
                    o_s_val = VAL_W'(1);
                    if (i_carry) begin
                        o_y_en  = 1'b1;
                        o_y_sel = 2'd1;
                    end
                end
            end
            S_UPD_X: begin
                o_regime = 2'd3;
                o_ch     = r_ch;
                o_y_en   = 1'b1;
                o_y_sel  = 2'd0;
            end
            S_UPD_NXT: begin
                o_regime = 2'd3;
                o_ch     = r_ch;
                o_y_en   = 1'b1;
                o_y_sel  = 2'd2;
            end
            S_UPD_CLR: begin
                o_regime = 2'd3;
                o_ch     = r_ch;
                o_s_en   = 1'b1;
                o_s_op   = OP_LOAD;
                o_s_val  = '0;
                o_done   = (r_ch == LAST_CH);
            end
            default: o_regime = 2'd0;
        endcase
    end

endmodule

// File: doc/regime_ctrl.md
REGIME_CTRL -- requirements
Module: regime_ctrl

Interface
REQ-001 Parameter N_CH, default 4: number of datapath channels (1..16).
REQ-002 Parameter CH_W, default 2: channel index width; satisfies 2**CH_W >= N_CH.
REQ-003 Parameter VAL_W, default 4: width of countdown value and s_val.
REQ-004 Parameter DWELL, default 3: cycles each countdown value is held (>=1).
REQ-005 Parameter CD_START, default 6: countdown start value; CD_STEP, default 2: countdown decrement (>=1).
REQ-006 clk  in  1  clock; all state changes on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 mode  in  2  requested regime: 0 off, 1 countdown, 2 count, 3 update.
REQ-009 start  in  1  level: arms countdown; holds count running.
REQ-010 ch_sel  in  CH_W  channel used by count regime.
REQ-011 carry  in  1  datapath flag: s add will wrap; y must increment.
REQ-012 regime  out  2  current regime: 0 OFF, 1 ARM/CD_*, 2 CNT, 3 UPD_*.
REQ-013 active  out  1  high in every CD_* state.
REQ-014 ch  out  CH_W  channel addressed by current strobes.
REQ-015 s_en / s_op[1:0] / s_val[VAL_W-1:0]  out  s register strobe, op (0 hold, 1 load, 2 add, 3 sub), operand.
REQ-016 y_en / y_sel[1:0]  out  y register strobe, source (0 load x, 1 increment, 2 next).
REQ-017 done  out  1  one-cycle pulse at completion of countdown or update.

Function
REQ-018 States: OFF, ARM, CD_LOAD, CD_HOLD, CD_STEP, CD_END, CNT, UPD_X, UPD_NXT, UPD_CLR; outputs are decoded from registered state, cd_val, dwell counter, ch; only CNT strobes depend on start/carry.
REQ-019 Unlisted outputs are 0 in every state; s_val=0 when s_en=0.
REQ-020 OFF: mode 0 stays; 1 -> ARM; 2 -> CNT, ch <= min(ch_sel, N_CH-1); 3 -> UPD_X, ch <= 0.
REQ-021 ARM: start=1 -> CD_LOAD; mode=0 with start=0 -> OFF; otherwise stay.
REQ-022 CD_LOAD (1 cycle): s_en=1, s_op=load, s_val=CD_START; cd_val <= CD_START; dwell <= DWELL-1; -> CD_HOLD.
REQ-023 CD_HOLD: dwell decrements each cycle; at dwell=0 -> CD_END if cd_val=0, else CD_STEP.
REQ-024 CD_STEP (1 cycle): s_en=1, s_op=sub, s_val=min(CD_STEP, cd_val); cd_val saturates at 0 (never wraps); dwell <= DWELL-1; -> CD_HOLD.
REQ-025 CD_END (1 cycle): s_en=1, s_op=load, s_val=CD_START (restore); done=1; -> OFF.
REQ-026 Countdown ignores mode and start once CD_LOAD entered; only rst aborts it.
REQ-027 CNT: start=1 -> s_en=1, s_op=add, s_val=1; additionally y_en=1, y_sel=1 in the same cycle iff carry=1; start=0 -> no strobes, -> OFF next edge; mode ignored; ch_sel changes ignored while in CNT.
REQ-028 UPD_X: y_en=1, y_sel=0 -> UPD_NXT; UPD_NXT: y_en=1, y_sel=2 -> UPD_CLR; UPD_CLR: s_en=1, s_op=load, s_val=0.
REQ-029 UPD_CLR with ch<N_CH-1: ch <= ch+1, -> UPD_X; with ch=N_CH-1: done=1, ch <= 0, -> OFF; mode/start ignored throughout update.
REQ-030 Update duration exactly 3*N_CH cycles; countdown duration exactly 2 + (CD_START/CD_STEP rounded up)*(DWELL+1) + DWELL cycles from CD_LOAD to CD_END inclusive.
REQ-031 Entering OFF from any state produces no strobe in the OFF cycle.

Reset
REQ-032 rst=1 forces state OFF, cd_val=0, dwell=0, ch=0 immediately; all outputs 0 while rst high.
REQ-033 rst asserted mid-countdown or mid-update aborts without done pulse or restore load; first cycle after release is OFF.

Verification
REQ-034 Defaults, mode=1, start=1 at edge 0 -> CD_LOAD cycle 1 (load 6); sub 2 in cycles 5, 9, 13; done + load 6 in cycle 17; regime=0 cycle 18; active=1 cycles 1-17.
REQ-035 CD_START=5, CD_STEP=2 -> sub operands 2, 2, 1; cd_val 5,3,1,0; done after final hold, no underflow.
REQ-036 mode=2, ch_sel=1, start=1 for 5 cycles, carry=1 in 3rd -> 5 add-1 strobes, ch=1, one y_en (y_sel=1) in 3rd cycle; start=0 -> OFF next edge.
REQ-037 mode=3 -> 12 cycles: per ch 0..3 sequence y load x, y next, s load 0; done in 12th cycle only.
REQ-038 rst pulse in CD_HOLD (cycle 7) -> outputs 0 immediately, no done, regime=0; ch_sel=7 with N_CH=4 in CNT -> ch=3.
